seg_scan_display: RTL

- Parametrised successor to the fixed-width seven-segment driver.
- Drives DIGITS seven-segment digits from a loaded hex buffer.
- Display modes: static, scroll-left (rotate), blink and off; mode steps come from an internal prescaler.
- Sits under the board top level; fed by a valid/ready load port from control logic, and its seg output goes straight to board pins.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_tick_gen.sv | 35 +++
 rtl/seg_scan_display.sv | 121 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the scanned seven-segment display.
// SEG_BLANK is the active-high "all segments off" pattern; polarity is applied by seg_polar.
package seg_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_SCROLL = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_OFF    = 2'b11
  } seg_mode_t;

  // Active-high gfedcba patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // dp (bit 7) is never lit
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    return {1'b0, HEX_SEG[nib]};
  endfunction

  function automatic logic [7:0] seg_polar(input logic [7:0] pat, input logic active_low);
    return active_low ? ~pat : pat;
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Step prescaler: cnt runs 0..TICK_DIV-1; step is a registered flag that is high while cnt==TICK_DIV-1.
// clr restarts the count synchronously and suppresses the pulse.
module seg_tick_gen #(
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic step
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      step <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      step <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      step <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multi-digit seven-segment driver with static/scroll/blink/off modes and a valid/ready load port.
// Optional SEG_BLANK_LEADING_ZERO_EN blanks leading zero digits in static and blink modes.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int TICK_DIV       = 5000000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [1:0]            load_mode,
  output logic [8*DIGITS-1:0]   seg,
  output logic                  step
);

  localparam int PW = $clog2(DIGITS);
  localparam int SW = PW + 1;
  localparam logic ACT_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic [7:0] SEG_OFF = seg_polar(SEG_BLANK, ACT_LOW);

  logic [4*DIGITS-1:0] data_q;
  seg_mode_t           mode_q;
  logic [PW-1:0]       ptr;
  logic                phase;
  logic                accept;
  logic                tick;
  logic [7:0]          seg_d [DIGITS];

  assign accept = load_valid & load_ready;
  // A load on the tick edge wins: the tick is dropped, not deferred
  assign tick   = step & ~accept;

  seg_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .step (step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      mode_q     <= MODE_OFF;
      ptr        <= '0;
      phase      <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      load_ready <= ~accept;
      if (accept) begin
        data_q <= load_data;
        mode_q <= seg_mode_t'(load_mode);
        ptr    <= '0;
        phase  <= 1'b0;
      end else if (tick) begin
        if (mode_q == MODE_SCROLL) begin
          ptr <= (ptr == PW'(DIGITS - 1)) ? '0 : ptr + 1'b1;
        end
        if (mode_q == MODE_BLINK) begin
          phase <= ~phase;
        end
      end
    end
  end

`ifdef SEG_BLANK_LEADING_ZERO_EN
  logic [DIGITS-1:0] lz;
  logic              lz_seen;

  // Scan from the top digit down; digit 0 is never blanked
  always_comb begin
    lz      = '0;
    lz_seen = 1'b0;
    for (int unsigned k = 0; k < DIGITS - 1; k++) begin
      if (data_q[4*(DIGITS-1-k) +: 4] != 4'h0) begin
        lz_seen = 1'b1;
      end
      lz[DIGITS-1-k] = ~lz_seen;
    end
  end
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [SW-1:0] sum;
    logic [PW-1:0] idx;
    logic          blank;

    // Explicit wrap so non-power-of-two DIGITS rotate correctly
    always_comb begin
      sum = SW'(g) + {1'b0, ptr};
      idx = PW'(g);
      if (mode_q == MODE_SCROLL) begin
        idx = (sum >= SW'(DIGITS)) ? PW'(sum - SW'(DIGITS)) : PW'(sum);
      end
      blank = (mode_q == MODE_OFF) || ((mode_q == MODE_BLINK) && phase);
`ifdef SEG_BLANK_LEADING_ZERO_EN
      if (((mode_q == MODE_STATIC) || (mode_q == MODE_BLINK)) && lz[g]) begin
        blank = 1'b1;
      end
`endif
    end

    assign seg_d[g] = seg_polar(blank ? SEG_BLANK : seg_decode(data_q[4*idx +: 4]), ACT_LOW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= {DIGITS{SEG_OFF}};
    end else begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        seg[8*i +: 8] <= seg_d[i];
      end
    end
  end

endmodule
